ps2_frame_receiver: RTL and testbench

PS2_FRAME_RECEIVER -- requirements
Module: ps2_frame_receiver

---
 rtl/ps2_pkg.sv | 17 +
 rtl/ps2_sync_edge.sv | 29 ++
 rtl/ps2_frame_receiver.sv | 165 ++++++++++++++++
 tb/tb_ps2_frame_receiver.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] EXT_PREFIX   = 8'hE0;

  // 1 ms at 50 MHz
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 50000;

endpackage

// File: rtl/ps2_sync_edge.sv
// Multi-flop synchronizer for one PS/2 line plus a falling-edge detector.
module ps2_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Reset to the idle bus level so releasing reset never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign fall  = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 keyboard frame receiver: decodes 11-bit frames and folds F0/E0 prefixes
// into the break/extended flags of the following scan code.
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clock50,
  input  logic       reset,
  input  logic       keyboardClock,
  input  logic       keyboardData,
  output logic [7:0] scanCode,
  output logic       codeValid,
  output logic       isBreak,
  output logic       isExtended,
  output logic       frameError,
  output logic       busy
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  logic clk_level, clk_fall, data_level, unused_data_fall;

  ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clk   (clock50),
    .rst   (reset),
    .din   (keyboardClock),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_data_sync (
    .clk   (clock50),
    .rst   (reset),
    .din   (keyboardData),
    .level (data_level),
    .fall  (unused_data_fall)
  );

  ps2_state_e state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          brk_pend_q, brk_pend_d, ext_pend_q, ext_pend_d;
  logic [7:0]    scan_q, scan_d;
  logic          is_break_q, is_break_d, is_ext_q, is_ext_d;
  logic          code_valid_q, code_valid_d, frame_error_q, frame_error_d;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    parity_d      = parity_q;
    brk_pend_d    = brk_pend_q;
    ext_pend_d    = ext_pend_q;
    scan_d        = scan_q;
    is_break_d    = is_break_q;
    is_ext_d      = is_ext_q;
    code_valid_d  = 1'b0;
    frame_error_d = 1'b0;

    if (state_q == StIdle || clk_fall) begin
      tmo_d = '0;
    end else if (tmo_q != TMAX) begin
      tmo_d = tmo_q + 1'b1;
    end else begin
      tmo_d = tmo_q;
    end

    unique case (state_q)
      StIdle: begin
        if (clk_fall && !data_level) begin
          state_d   = StData;
          bit_cnt_d = 3'd0;
        end
      end
      StData: begin
        if (clk_fall) begin
          shift_d   = {data_level, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (clk_fall) begin
          parity_d = data_level;
          state_d  = StStop;
        end
      end
      StStop: begin
        if (clk_fall) begin
          state_d = StIdle;
          if (data_level && (^{shift_q, parity_q})) begin
            if (shift_q == BREAK_PREFIX) begin
              brk_pend_d = 1'b1;
            end else if (shift_q == EXT_PREFIX) begin
              ext_pend_d = 1'b1;
            end else begin
              scan_d       = shift_q;
              is_break_d   = brk_pend_q;
              is_ext_d     = ext_pend_q;
              brk_pend_d   = 1'b0;
              ext_pend_d   = 1'b0;
              code_valid_d = 1'b1;
            end
          end else begin
            frame_error_d = 1'b1;
            brk_pend_d    = 1'b0;
            ext_pend_d    = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A falling edge in the same cycle restarts the window instead.
    if (state_q != StIdle && !clk_fall && tmo_q == TMAX) begin
      state_d       = StIdle;
      frame_error_d = 1'b1;
      brk_pend_d    = 1'b0;
      ext_pend_d    = 1'b0;
    end
  end

  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      tmo_q         <= '0;
      brk_pend_q    <= 1'b0;
      ext_pend_q    <= 1'b0;
      scan_q        <= '0;
      is_break_q    <= 1'b0;
      is_ext_q      <= 1'b0;
      code_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      tmo_q         <= tmo_d;
      brk_pend_q    <= brk_pend_d;
      ext_pend_q    <= ext_pend_d;
      scan_q        <= scan_d;
      is_break_q    <= is_break_d;
      is_ext_q      <= is_ext_d;
      code_valid_q  <= code_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign scanCode   = scan_q;
  assign isBreak    = is_break_q;
  assign isExtended = is_ext_q;
  assign codeValid  = code_valid_q;
  assign frameError = frame_error_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Scoreboard bench for ps2_frame_receiver: frames are bit-banged on the PS/2 pins.
module tb_ps2_frame_receiver;

  localparam int unsigned TMO = 50000;

  logic       clock50, reset, keyboardClock, keyboardData;
  logic [7:0] scanCode;
  logic       codeValid, isBreak, isExtended, frameError, busy;

  ps2_frame_receiver #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clock50       (clock50),
    .reset         (reset),
    .keyboardClock (keyboardClock),
    .keyboardData  (keyboardData),
    .scanCode      (scanCode),
    .codeValid     (codeValid),
    .isBreak       (isBreak),
    .isExtended    (isExtended),
    .frameError    (frameError),
    .busy          (busy)
  );

  initial clock50 = 1'b0;
  always #10 clock50 = ~clock50;

  typedef struct {
    bit         err;
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_code = 8'h00;
  logic       exp_brk  = 1'b0;
  logic       exp_ext  = 1'b0;
  time        last_fall_time = 0;

  // Scoreboard: every strobe must match the oldest pending expectation.
  always @(negedge clock50) begin
    if (codeValid === 1'b1 && frameError === 1'b1) begin
      n_checks++;
      $display("FAIL strobe_exclusive: codeValid=1 frameError=1, required not both");
    end else if (codeValid === 1'b1 || frameError === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_strobe: codeValid=%b frameError=%b scanCode=%h, required none",
                 codeValid, frameError, scanCode);
      end else begin
        mon_e = exp_q.pop_front();
        if ((mon_e.err ? 1'b1 : 1'b0) !== frameError ||
            (!mon_e.err && ({scanCode, isBreak, isExtended} !==
                            {mon_e.code, mon_e.brk, mon_e.ext}))) begin
          $display("FAIL strobe_content: err=%b code=%h brk=%b ext=%b, required err=%b code=%h brk=%b ext=%b",
                   frameError, scanCode, isBreak, isExtended,
                   mon_e.err, mon_e.code, mon_e.brk, mon_e.ext);
        end else begin
          n_pass++;
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    keyboardData = b;
    repeat (4) @(negedge clock50);
    keyboardClock  = 1'b0;
    last_fall_time = $time;
    repeat (8) @(negedge clock50);
    keyboardClock = 1'b1;
    repeat (4) @(negedge clock50);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_parity, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit((~^b) ^ bad_parity);
    drive_bit(stop);
    keyboardData = 1'b1;
  endtask

  task automatic expect_code(input logic [7:0] b);
    exp_t e;
    e.err = 1'b0; e.code = b; e.brk = exp_brk; e.ext = exp_ext;
    exp_q.push_back(e);
    exp_code = b;
  endtask

  task automatic expect_error();
    exp_t e;
    e.err = 1'b1; e.code = 8'h00; e.brk = 1'b0; e.ext = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1; keyboardClock = 1'b1; keyboardData = 1'b1;
    repeat (3) @(negedge clock50);
    n_checks++;
    if ({scanCode, codeValid, isBreak, isExtended, frameError, busy} !== 13'h0)
      $display("FAIL reset_outputs: %h %b %b %b %b %b, required all 0",
               scanCode, codeValid, isBreak, isExtended, frameError, busy);
    else n_pass++;
    reset = 1'b0;
    repeat (10) @(negedge clock50);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_release_busy: busy=%b, required 0", busy);
    else n_pass++;
  endtask

  task automatic test_idle_high_edge();
    drive_bit(1'b1);
    repeat (4) @(negedge clock50);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL idle_high_edge_busy: busy=%b, required 0", busy);
    else n_pass++;
  endtask

  task automatic test_make_code();
    exp_brk = 1'b0; exp_ext = 1'b0;
    expect_code(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1);
    repeat (20) @(negedge clock50);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL make_code_drain: pending=%0d, required 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if ({scanCode, isBreak, isExtended} !== {8'h1C, 2'b00})
      $display("FAIL make_code_hold: %h %b %b, required 1c 0 0", scanCode, isBreak, isExtended);
    else n_pass++;
  endtask

  task automatic test_break();
    send_frame(8'hF0, 1'b0, 1'b1);
    exp_brk = 1'b1; exp_ext = 1'b0;
    expect_code(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1);
    repeat (20) @(negedge clock50);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL break_drain: pending=%0d, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    exp_brk = 1'b1; exp_ext = 1'b1;
    expect_code(8'h75);
    send_frame(8'h75, 1'b0, 1'b1);
    repeat (20) @(negedge clock50);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL ext_break_drain: pending=%0d, required 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if ({scanCode, isBreak, isExtended} !== {8'h75, 2'b11})
      $display("FAIL ext_break_hold: %h %b %b, required 75 1 1", scanCode, isBreak, isExtended);
    else n_pass++;
  endtask

  task automatic test_frame_errors();
    expect_error();
    send_frame(8'h1C, 1'b1, 1'b1);
    expect_error();
    send_frame(8'h2A, 1'b0, 1'b0);
    repeat (20) @(negedge clock50);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL errors_drain: pending=%0d, required 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if ({scanCode, isBreak, isExtended} !== {exp_code, exp_brk, exp_ext})
      $display("FAIL errors_hold: %h %b %b, required %h %b %b",
               scanCode, isBreak, isExtended, exp_code, exp_brk, exp_ext);
    else n_pass++;
  endtask

  task automatic test_error_clears_prefix();
    send_frame(8'hF0, 1'b0, 1'b1);
    expect_error();
    send_frame(8'h33, 1'b1, 1'b1);
    exp_brk = 1'b0; exp_ext = 1'b0;
    expect_code(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1);
    repeat (20) @(negedge clock50);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL clear_prefix_drain: pending=%0d, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_timeout();
    int seen_at;
    logic [3:0] partial;
    seen_at = -1;
    partial = 4'b1010;
    send_frame(8'hE0, 1'b0, 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(partial[i]);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL timeout_busy_mid: busy=%b, required 1", busy);
    else n_pass++;
    expect_error();
    for (int c = 0; c < 60000; c++) begin
      @(negedge clock50);
      if (frameError === 1'b1 && seen_at < 0)
        seen_at = int'(($time - last_fall_time) / 20);
    end
    n_checks++;
    if (seen_at < int'(TMO) || seen_at > int'(TMO) + 6)
      $display("FAIL timeout_latency: cycles=%0d, required %0d..%0d", seen_at, TMO, TMO + 6);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL timeout_busy_after: busy=%b, required 0", busy);
    else n_pass++;
    exp_brk = 1'b0; exp_ext = 1'b0;
    expect_code(8'h32);
    send_frame(8'h32, 1'b0, 1'b1);
    repeat (20) @(negedge clock50);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL timeout_drain: pending=%0d, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [4:0] partial;
    partial = 5'b10110;
    drive_bit(1'b0);
    for (int i = 0; i < 5; i++) drive_bit(partial[i]);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL reset_mid_busy_before: busy=%b, required 1", busy);
    else n_pass++;
    reset = 1'b1;
    repeat (3) @(negedge clock50);
    n_checks++;
    if ({scanCode, codeValid, isBreak, isExtended, frameError, busy} !== 13'h0)
      $display("FAIL reset_mid_outputs: %h %b %b %b %b %b, required all 0",
               scanCode, codeValid, isBreak, isExtended, frameError, busy);
    else n_pass++;
    reset = 1'b0;
    exp_code = 8'h00; exp_brk = 1'b0; exp_ext = 1'b0;
    repeat (10) @(negedge clock50);
    expect_code(8'h45);
    send_frame(8'h45, 1'b0, 1'b1);
    repeat (20) @(negedge clock50);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL reset_mid_drain: pending=%0d, required 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if ({scanCode, isBreak, isExtended} !== {8'h45, 2'b00})
      $display("FAIL reset_mid_hold: %h %b %b, required 45 0 0", scanCode, isBreak, isExtended);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_idle_high_edge();
    test_make_code();
    test_break();
    test_back_to_back();
    test_frame_errors();
    test_error_clears_prefix();
    test_timeout();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
